// File: rtl/nn_avalon_burst_slave.sv
// Avalon-MM burst slave for the NN accelerator.
// Routes pixel/weight writes to buffers, serves results and the control/status word.
module nn_avalon_burst_slave #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 11,
    parameter int BURST_W   = 10,
    parameter int STORE_W   = 16,
    parameter int RESULT_W  = 17,
    parameter int PIX_DEPTH = 784,
    parameter int WGT_DEPTH = 784,
    parameter int RES_DEPTH = 10,
    parameter int RA_W      = $clog2(RES_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write,
    input  logic                read,
    input  logic                beginbursttransfer,
    input  logic [BURST_W-1:0]  burstcount,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                waitrequest,
    output logic                readdatavalid,
    output logic                writeresponsevalid,
    output logic [1:0]          response,
    output logic                pixel_we,
    output logic                weight_we,
    output logic [ADDR_W-1:0]   pixel_addr,
    output logic [ADDR_W-1:0]   weight_addr,
    output logic [STORE_W-1:0]  store_data,
    output logic [RA_W-1:0]     result_addr,
    input  logic [RESULT_W-1:0] result_output,
    output logic                start_calc,
    input  logic                done_calc,
    output logic                irq
);
    // One extra bit so a burst running past the top of the address space decodes as unmapped.
    localparam int BA_W = ((ADDR_W > BURST_W) ? ADDR_W : BURST_W) + 1;
    localparam logic [BA_W-1:0] WGT_BASE = BA_W'(PIX_DEPTH);
    localparam logic [BA_W-1:0] RES_BASE = BA_W'(PIX_DEPTH + WGT_DEPTH);
    localparam logic [BA_W-1:0] CSR_ADDR = BA_W'(PIX_DEPTH + WGT_DEPTH + RES_DEPTH);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, WR_RESP} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0]  base_q;
    logic [BURST_W-1:0] offs_q, rem_q, eff_count;
    logic               wr_err_q;
    logic               rvalid_q;
    logic [DATA_W-1:0]  rdata_q, csr_val, rd_word;
    logic [1:0]         rresp_q;
    logic               busy_q, done_q, irq_en_q, irq_q;
    logic [BA_W-1:0]    beat_addr;
    logic               hit_pix, hit_wgt, hit_res, hit_csr, hit_unm;
    logic               wr_beat, rd_beat, csr_wr, start_req, beat_err;
    logic               unused_bits;

    assign unused_bits = &{1'b0, beginbursttransfer, writedata};
    assign eff_count   = (burstcount == '0) ? BURST_W'(1) : burstcount;

    always_comb begin
        if (state == IDLE)
            beat_addr = {{(BA_W-ADDR_W){1'b0}}, address};
        else
            beat_addr = {{(BA_W-ADDR_W){1'b0}}, base_q} + {{(BA_W-BURST_W){1'b0}}, offs_q};
    end

    assign hit_pix = beat_addr < WGT_BASE;
    assign hit_wgt = (beat_addr >= WGT_BASE) && (beat_addr < RES_BASE);
    assign hit_res = (beat_addr >= RES_BASE) && (beat_addr < CSR_ADDR);
    assign hit_csr = beat_addr == CSR_ADDR;
    assign hit_unm = beat_addr > CSR_ADDR;

    assign csr_wr    = wr_beat & hit_csr;
    assign start_req = csr_wr & writedata[0];
    assign beat_err  = hit_res | hit_unm | (start_req & busy_q);
    assign csr_val   = DATA_W'({irq_en_q, done_q, busy_q, 1'b0});
    assign rd_word   = hit_res ? DATA_W'(result_output) : (hit_csr ? csr_val : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (write)     state_nxt = (eff_count == BURST_W'(1)) ? WR_RESP : WR_BURST;
                else if (read) state_nxt = RD_BURST;
            end
            WR_BURST: if (write && rem_q == BURST_W'(1)) state_nxt = WR_RESP;
            RD_BURST: if (rem_q == BURST_W'(1)) state_nxt = IDLE;
            WR_RESP:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        waitrequest        = 1'b0;
        writeresponsevalid = 1'b0;
        response           = rvalid_q ? rresp_q : 2'b00;
        wr_beat            = 1'b0;
        rd_beat            = 1'b0;
        case (state)
            IDLE, WR_BURST: wr_beat = write & ~rst;
            RD_BURST: begin
                waitrequest = 1'b1;
                rd_beat     = ~rst;
            end
            WR_RESP: begin
                waitrequest        = 1'b1;
                writeresponsevalid = 1'b1;
                response           = {wr_err_q, 1'b0};
            end
            default: ;
        endcase
    end

    assign pixel_we      = wr_beat & hit_pix;
    assign weight_we     = wr_beat & hit_wgt;
    assign pixel_addr    = pixel_we ? beat_addr[ADDR_W-1:0] : '0;
    assign weight_addr   = weight_we ? ADDR_W'(beat_addr - WGT_BASE) : '0;
    assign store_data    = (pixel_we | weight_we) ? writedata[STORE_W-1:0] : '0;
    assign result_addr   = (rd_beat & hit_res) ? RA_W'(beat_addr - RES_BASE) : '0;
    assign start_calc    = start_req & ~busy_q;
    assign readdatavalid = rvalid_q;
    assign readdata      = rdata_q;
    assign irq           = irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q   <= '0;
            offs_q   <= '0;
            rem_q    <= '0;
            wr_err_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rvalid_q <= rd_beat;
            rdata_q  <= rd_beat ? rd_word : '0;
            rresp_q  <= (rd_beat && !(hit_res || hit_csr)) ? 2'b10 : 2'b00;
            case (state)
                IDLE: begin
                    if (write) begin
                        base_q   <= address;
                        offs_q   <= BURST_W'(1);
                        rem_q    <= eff_count - BURST_W'(1);
                        wr_err_q <= beat_err;
                    end else if (read) begin
                        base_q <= address;
                        offs_q <= '0;
                        rem_q  <= eff_count;
                    end
                end
                WR_BURST: begin
                    if (write) begin
                        offs_q   <= offs_q + BURST_W'(1);
                        rem_q    <= rem_q - BURST_W'(1);
                        wr_err_q <= wr_err_q | beat_err;
                    end
                end
                RD_BURST: begin
                    offs_q <= offs_q + BURST_W'(1);
                    rem_q  <= rem_q - BURST_W'(1);
                end
                default: ;
            endcase
            if (start_calc)     busy_q <= 1'b1;
            else if (done_calc) busy_q <= 1'b0;
            // A completion arriving in the same cycle as a software clear must not be lost.
            if (done_calc)                     done_q <= 1'b1;
            else if (csr_wr && writedata[2])   done_q <= 1'b0;
            if (csr_wr) irq_en_q <= writedata[3];
            irq_q <= done_q & irq_en_q;
        end
    end
endmodule

// File: tb/tb_nn_avalon_burst_slave.sv
// Directed bench for nn_avalon_burst_slave: buffer writes, result/CSR reads,
// control handshake, error responses and reset during a burst.
module tb_nn_avalon_burst_slave;
    logic        clk = 1'b0;
    logic        rst, write, read, beginbursttransfer, done_calc;
    logic [9:0]  burstcount;
    logic [10:0] address;
    logic [31:0] writedata, readdata;
    logic        waitrequest, readdatavalid, writeresponsevalid;
    logic [1:0]  response;
    logic        pixel_we, weight_we, start_calc, irq;
    logic [10:0] pixel_addr, weight_addr;
    logic [15:0] store_data;
    logic [3:0]  result_addr;
    logic [16:0] result_output;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Result buffer stand-in: entry n holds 0x10000 + 5*n.
    assign result_output = 17'h10000 + 17'(result_addr) * 17'd5;

    nn_avalon_burst_slave dut (
        .clk(clk), .rst(rst), .write(write), .read(read),
        .beginbursttransfer(beginbursttransfer), .burstcount(burstcount),
        .address(address), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .readdatavalid(readdatavalid),
        .writeresponsevalid(writeresponsevalid), .response(response),
        .pixel_we(pixel_we), .weight_we(weight_we), .pixel_addr(pixel_addr),
        .weight_addr(weight_addr), .store_data(store_data),
        .result_addr(result_addr), .result_output(result_output),
        .start_calc(start_calc), .done_calc(done_calc), .irq(irq)
    );

    task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wbeat(input string tag, input logic [10:0] a, input logic [9:0] cnt, input bit first,
                         input logic [31:0] d, input bit epw, input bit eww, input logic [10:0] eaddr,
                         input bit estart);
        logic [15:0] es;
        es = (epw | eww) ? d[15:0] : 16'h0;
        write = 1'b1;
        writedata = d;
        beginbursttransfer = first;
        if (first) begin
            address = a;
            burstcount = cnt;
        end
        #1;
        chk(tag, "pixel_we", pixel_we, epw);
        chk(tag, "weight_we", weight_we, eww);
        chk(tag, "pixel_addr", pixel_addr, epw ? eaddr : 11'h0);
        chk(tag, "weight_addr", weight_addr, eww ? eaddr : 11'h0);
        chk(tag, "store_data", store_data, es);
        chk(tag, "start_calc", start_calc, estart);
        chk(tag, "waitrequest", waitrequest, 1'b0);
        tick();
        write = 1'b0;
        beginbursttransfer = 1'b0;
    endtask

    task automatic wresp(input string tag, input logic [1:0] er);
        #1;
        chk(tag, "wrvalid", writeresponsevalid, 1'b1);
        chk(tag, "response", response, er);
        chk(tag, "waitrequest_resp", waitrequest, 1'b1);
        chk(tag, "pixel_we_resp", pixel_we | weight_we | start_calc, 1'b0);
        tick();
        #1;
        chk(tag, "wrvalid_after", writeresponsevalid, 1'b0);
        chk(tag, "response_after", response, 2'b00);
    endtask

    task automatic rd_burst(input string tag, input logic [10:0] a, input int n, input logic [31:0] d0,
                            input logic [31:0] step, input logic [1:0] er, input bit is_res);
        read = 1'b1;
        address = a;
        burstcount = 10'(n);
        beginbursttransfer = 1'b1;
        #1;
        chk(tag, "waitrequest_idle", waitrequest, 1'b0);
        tick();
        read = 1'b0;
        beginbursttransfer = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk(tag, "waitrequest", waitrequest, 1'b1);
            chk(tag, "result_addr", result_addr, is_res ? 4'(i) : 4'h0);
            chk(tag, "rvalid", readdatavalid, i > 0);
            if (i > 0) begin
                chk(tag, "readdata", readdata, d0 + step * 32'(i - 1));
                chk(tag, "rresp", response, er);
            end
            tick();
        end
        #1;
        chk(tag, "rvalid_last", readdatavalid, 1'b1);
        chk(tag, "readdata_last", readdata, d0 + step * 32'(n - 1));
        chk(tag, "rresp_last", response, er);
        chk(tag, "waitrequest_last", waitrequest, 1'b0);
        tick();
        #1;
        chk(tag, "rvalid_end", readdatavalid, 1'b0);
        chk(tag, "response_end", response, 2'b00);
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; read = 1'b0; beginbursttransfer = 1'b0; done_calc = 1'b0;
        burstcount = 10'd0; address = 11'd0; writedata = 32'd0;
        #3;
        chk("reset", "waitrequest", waitrequest, 1'b0);
        chk("reset", "rvalid", readdatavalid, 1'b0);
        chk("reset", "wrvalid", writeresponsevalid, 1'b0);
        chk("reset", "irq", irq, 1'b0);
        chk("reset", "start_calc", start_calc, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Four pixel writes from address 0
        wbeat("wr_pix", 11'd0, 10'd4, 1'b1, 32'd1, 1'b1, 1'b0, 11'd0, 1'b0);
        wbeat("wr_pix", 11'd0, 10'd4, 1'b0, 32'd2, 1'b1, 1'b0, 11'd1, 1'b0);
        wbeat("wr_pix", 11'd0, 10'd4, 1'b0, 32'd3, 1'b1, 1'b0, 11'd2, 1'b0);
        wbeat("wr_pix", 11'd0, 10'd4, 1'b0, 32'd4, 1'b1, 1'b0, 11'd3, 1'b0);
        wresp("wr_pix", 2'b00);

        // Burst crossing pixel -> weight region; upper data bits must not reach store_data
        wbeat("wr_cross", 11'd782, 10'd4, 1'b1, 32'hABCD_0010, 1'b1, 1'b0, 11'd782, 1'b0);
        wbeat("wr_cross", 11'd782, 10'd4, 1'b0, 32'hABCD_0011, 1'b1, 1'b0, 11'd783, 1'b0);
        wbeat("wr_cross", 11'd782, 10'd4, 1'b0, 32'hABCD_0012, 1'b0, 1'b1, 11'd0, 1'b0);
        wbeat("wr_cross", 11'd782, 10'd4, 1'b0, 32'hABCD_0013, 1'b0, 1'b1, 11'd1, 1'b0);
        wresp("wr_cross", 2'b00);

        // Idle cycle inside a write burst
        wbeat("wr_gap", 11'd100, 10'd2, 1'b1, 32'h0000_0AAA, 1'b1, 1'b0, 11'd100, 1'b0);
        #1;
        chk("wr_gap", "pixel_we_idle", pixel_we, 1'b0);
        chk("wr_gap", "wrvalid_idle", writeresponsevalid, 1'b0);
        chk("wr_gap", "waitrequest_idle", waitrequest, 1'b0);
        tick();
        wbeat("wr_gap", 11'd100, 10'd2, 1'b0, 32'h0000_0BBB, 1'b1, 1'b0, 11'd101, 1'b0);
        wresp("wr_gap", 2'b00);

        // burstcount 0 is a single beat
        wbeat("wr_cnt0", 11'd10, 10'd0, 1'b1, 32'd7, 1'b1, 1'b0, 11'd10, 1'b0);
        wresp("wr_cnt0", 2'b00);

        rd_burst("rd_res", 11'd1568, 10, 32'h10000, 32'd5, 2'b00, 1'b1);
        rd_burst("rd_pix", 11'd5, 2, 32'd0, 32'd0, 2'b10, 1'b0);

        // Start with IRQ enable
        wbeat("csr_start", 11'd1578, 10'd1, 1'b1, 32'h9, 1'b0, 1'b0, 11'd0, 1'b1);
        wresp("csr_start", 2'b00);
        rd_burst("csr_busy", 11'd1578, 1, 32'hA, 32'd0, 2'b00, 1'b0);

        wbeat("csr_restart", 11'd1578, 10'd1, 1'b1, 32'h9, 1'b0, 1'b0, 11'd0, 1'b0);
        wresp("csr_restart", 2'b10);
        wbeat("wr_res", 11'd1570, 10'd1, 1'b1, 32'h1234, 1'b0, 1'b0, 11'd0, 1'b0);
        wresp("wr_res", 2'b10);
        wbeat("wr_unmapped", 11'd1600, 10'd1, 1'b1, 32'h1234, 1'b0, 1'b0, 11'd0, 1'b0);
        wresp("wr_unmapped", 2'b10);

        done_calc = 1'b1;
        tick();
        done_calc = 1'b0;
        #1;
        chk("done", "irq_reg_delay", irq, 1'b0);
        tick();
        chk("done", "irq", irq, 1'b1);
        rd_burst("csr_done", 11'd1578, 1, 32'hC, 32'd0, 2'b00, 1'b0);

        wbeat("csr_clr", 11'd1578, 10'd1, 1'b1, 32'h4, 1'b0, 1'b0, 11'd0, 1'b0);
        wresp("csr_clr", 2'b00);
        chk("csr_clr", "irq", irq, 1'b0);
        rd_burst("csr_clr_rd", 11'd1578, 1, 32'h0, 32'd0, 2'b00, 1'b0);

        // done_calc coincident with the DONE clear: DONE stays set
        done_calc = 1'b1;
        wbeat("csr_setwins", 11'd1578, 10'd1, 1'b1, 32'h4, 1'b0, 1'b0, 11'd0, 1'b0);
        done_calc = 1'b0;
        wresp("csr_setwins", 2'b00);
        rd_burst("csr_setwins_rd", 11'd1578, 1, 32'h4, 32'd0, 2'b00, 1'b0);

        wbeat("csr_irqen", 11'd1578, 10'd1, 1'b1, 32'h8, 1'b0, 1'b0, 11'd0, 1'b0);
        wresp("csr_irqen", 2'b00);
        chk("csr_irqen", "irq", irq, 1'b1);

        // Reset in the middle of a result read burst
        read = 1'b1; address = 11'd1568; burstcount = 10'd10; beginbursttransfer = 1'b1;
        tick();
        read = 1'b0; beginbursttransfer = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_mid", "rvalid_before", readdatavalid, 1'b1);
        chk("rst_mid", "readdata_before", readdata, 32'h1000A);
        rst = 1'b1;
        #1;
        chk("rst_mid", "rvalid", readdatavalid, 1'b0);
        chk("rst_mid", "waitrequest", waitrequest, 1'b0);
        chk("rst_mid", "irq", irq, 1'b0);
        chk("rst_mid", "readdata", readdata, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rst_after", "rvalid", readdatavalid, 1'b0);
            chk("rst_after", "waitrequest", waitrequest, 1'b0);
            chk("rst_after", "wrvalid", writeresponsevalid, 1'b0);
            tick();
        end
        rd_burst("rst_csr", 11'd1578, 1, 32'h0, 32'd0, 2'b00, 1'b0);
        wbeat("rst_wr", 11'd3, 10'd1, 1'b1, 32'h55, 1'b1, 1'b0, 11'd3, 1'b0);
        wresp("rst_wr", 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
